// File: rtl/qam16_pkg.sv
// Shared types and helpers for the 16-QAM symbol mapper: constellation
// level type, Gray-to-level conversion, quadrant maps for the optional
// differential encoder (QAM_DIFF_ENC_EN), and the input buffer state enum.
package qam16_pkg;

  // Signed constellation level in units of AMP.
  typedef logic signed [2:0] level_t;

  localparam level_t LVL_M3 = level_t'(-3);
  localparam level_t LVL_M1 = level_t'(-1);
  localparam level_t LVL_P1 = level_t'(1);
  localparam level_t LVL_P3 = level_t'(3);

  // Occupancy of the one-byte input buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FULL_HI = 2'd1,  // next symbol comes from bits [7:4]
    BUF_FULL_LO = 2'd2   // next symbol comes from bits [3:0]
  } buf_state_t;

  // Gray-coded bit pair to amplitude level: 00->-3, 01->-1, 11->+1, 10->+3.
  function automatic level_t gray2level(input logic [1:0] g);
    case (g)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

  // Sign-bit pair (b3,b1) to quadrant index: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] quad_map(input logic [1:0] b31);
    case (b31)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Quadrant index back to the sign-bit pair (b3,b1).
  function automatic logic [1:0] quad_inv(input logic [1:0] quad);
    case (quad)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/qam16_gray_map.sv
// Combinational Gray mapper: nibble b3b2b1b0 -> (I, Q) where I comes from
// b3b2 and Q from b1b0, each scaled by AMP.
module qam16_gray_map
  import qam16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AMP    = 8192
) (
  input  logic        [3:0]        nibble,
  output logic signed [DATA_W-1:0] sym_i,
  output logic signed [DATA_W-1:0] sym_q
);

  level_t lvl_i;
  level_t lvl_q;

  // Look up both axis levels and scale them to the output amplitude.
  always_comb begin
    lvl_i = gray2level(nibble[3:2]);
    lvl_q = gray2level(nibble[1:0]);
    sym_i = DATA_W'(int'(lvl_i) * AMP);
    sym_q = DATA_W'(int'(lvl_q) * AMP);
  end

endmodule

// File: rtl/qam16_symbol_mapper.sv
// Byte stream to Gray-coded 16-QAM symbols, one symbol every OVERCLK_FACTOR
// enabled clocks. Holds one byte (two symbols) behind a valid/ready
// handshake and reports underruns. Define QAM_DIFF_ENC_EN to add
// differential quadrant encoding against the receiver PLL's 90-degree
// phase ambiguity.
module qam16_symbol_mapper
  import qam16_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int AMP            = 8192,
  parameter int OVERCLK_FACTOR = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic        [7:0]        din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] sym_i,
  output logic signed [DATA_W-1:0] sym_q,
  output logic                     sym_valid,
  output logic                     underrun,
  output logic        [15:0]       underrun_cnt
);

  localparam int               CNT_W   = $clog2(OVERCLK_FACTOR + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERCLK_FACTOR);

  logic        [CNT_W-1:0]  cnt;
  logic                     strobe;
  logic                     accept;
  buf_state_t               state;
  buf_state_t               state_nxt;
  logic        [7:0]        buf_byte;
  logic        [3:0]        nibble;
  logic        [3:0]        nibble_tx;
  logic signed [DATA_W-1:0] map_i;
  logic signed [DATA_W-1:0] map_q;

  assign strobe = clk_enable && (cnt == CNT_ONE);

  // Symbol-rate counter: 1..OVERCLK_FACTOR, frozen while clk_enable is low.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CNT_ONE;
    end else if (clk_enable) begin
      cnt <= (cnt == CNT_MAX) ? CNT_ONE : cnt + CNT_W'(1);
    end
  end

  // Buffer state register and byte storage.
  // NOTE: buf_byte is only read while the state says FULL, so its reset is
  // not functionally needed; it is cleared anyway to keep the datapath
  // free of X after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BUF_EMPTY;
      buf_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) buf_byte <= din;
    end
  end

  // Buffer next state: load on accept, step through nibbles on strobe.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY:   if (accept) state_nxt = BUF_FULL_HI;
      BUF_FULL_HI: if (strobe) state_nxt = BUF_FULL_LO;
      BUF_FULL_LO: if (strobe) state_nxt = accept ? BUF_FULL_HI : BUF_EMPTY;
      default:     state_nxt = BUF_EMPTY;
    endcase
  end

  // Buffer outputs: handshake and the nibble due at the next strobe.
  always_comb begin
    din_ready = (state == BUF_EMPTY) || ((state == BUF_FULL_LO) && strobe);
    accept    = din_valid && din_ready;
    nibble    = (state == BUF_FULL_HI) ? buf_byte[7:4] : buf_byte[3:0];
  end

`ifdef QAM_DIFF_ENC_EN
  logic       data_sym;
  logic [1:0] diff_s;
  logic [1:0] diff_s_nxt;
  logic [1:0] tx_b31;

  assign data_sym = strobe && (state != BUF_EMPTY);

  // Accumulate the data quadrant and transmit the absolute quadrant so the
  // receiver only has to decode phase differences.
  always_comb begin
    diff_s_nxt = diff_s + quad_map({nibble[3], nibble[1]});
    tx_b31     = quad_inv(diff_s_nxt);
    nibble_tx  = {tx_b31[1], nibble[2], tx_b31[0], nibble[0]};
  end

  // Differential state advances only on data symbols, never on underruns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      diff_s <= 2'd0;
    end else if (data_sym) begin
      diff_s <= diff_s_nxt;
    end
  end
`else
  assign nibble_tx = nibble;
`endif

  qam16_gray_map #(
    .DATA_W (DATA_W),
    .AMP    (AMP)
  ) u_gray_map (
    .nibble (nibble_tx),
    .sym_i  (map_i),
    .sym_q  (map_q)
  );

  // Output registers: new symbol or zero underrun symbol on each strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_i        <= '0;
      sym_q        <= '0;
      sym_valid    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'h0000;
    end else begin
      sym_valid <= strobe;
      underrun  <= strobe && (state == BUF_EMPTY);
      if (strobe) begin
        if (state == BUF_EMPTY) begin
          sym_i <= '0;
          sym_q <= '0;
          if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end else begin
          sym_i <= map_i;
          sym_q <= map_q;
        end
      end
    end
  end

endmodule
